// File: rtl/ysyx_22040386_dmem_resp.sv
// Single-outstanding data-memory responder for the MEM stage: 64-bit word array,
// byte-masked stores, aligned doubleword loads, fixed request-to-response latency.
module ysyx_22040386_dmem_resp #(
  parameter logic [63:0] ADDR_BASE = 64'h8000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2
) (
  input  logic        i_DMEM_clk,
  input  logic        i_DMEM_rst,
  input  logic        i_DMEM_req_valid,
  output logic        o_DMEM_req_ready,
  input  logic        i_DMEM_req_write,
  input  logic [63:0] i_DMEM_req_addr,
  input  logic [63:0] i_DMEM_req_wdata,
  input  logic [7:0]  i_DMEM_req_wmask,
  output logic        o_DMEM_rsp_valid,
  input  logic        i_DMEM_rsp_ready,
  output logic [63:0] o_DMEM_rsp_rdata,
  output logic        o_DMEM_rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;
  logic              req_fire;
  logic              enter_resp;
  logic              commit;

  logic              req_write;
  logic [63:0]       req_addr;
  logic [63:0]       req_wdata;
  logic [7:0]        req_wmask;

  logic              acc_write;
  logic [63:0]       acc_addr;
  logic [63:0]       acc_wdata;
  logic [7:0]        acc_wmask;
  logic [63:0]       off;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  logic [63:0]       rdata;
  logic              err;
  logic [63:0]       mem [DEPTH];

  assign o_DMEM_req_ready = (state == IDLE) && !i_DMEM_rst;
  assign req_fire         = i_DMEM_req_valid && o_DMEM_req_ready;
  assign o_DMEM_rsp_valid = (state == RESP);
  assign o_DMEM_rsp_rdata = rdata;
  assign o_DMEM_rsp_err   = err;

  // With LATENCY=1 the access edge is the handshake edge itself, so use live inputs there.
  assign acc_write = (state == IDLE) ? i_DMEM_req_write : req_write;
  assign acc_addr  = (state == IDLE) ? i_DMEM_req_addr  : req_addr;
  assign acc_wdata = (state == IDLE) ? i_DMEM_req_wdata : req_wdata;
  assign acc_wmask = (state == IDLE) ? i_DMEM_req_wmask : req_wmask;

  assign off      = acc_addr - ADDR_BASE;
  assign in_range = (acc_addr >= ADDR_BASE) && ((off >> 3) < 64'(DEPTH));
  assign idx      = off[IDX_W+2:3];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (req_fire) begin
          cnt_nxt   = 4'(LATENCY - 1);
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP: begin
        if (i_DMEM_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_resp = (state != RESP) && (state_nxt == RESP);
  assign commit     = enter_resp && !i_DMEM_rst;

  always_ff @(posedge i_DMEM_clk) begin
    if (i_DMEM_rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rdata <= 64'd0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (enter_resp) begin
        if (!in_range) begin
          rdata <= '1;
          err   <= 1'b1;
        end else if (acc_write) begin
          rdata <= 64'd0;
          err   <= 1'b0;
        end else begin
          rdata <= mem[idx];
          err   <= 1'b0;
        end
      end
    end
  end

  // Request capture: data only, no reset needed
  always_ff @(posedge i_DMEM_clk) begin
    if (req_fire) begin
      req_write <= i_DMEM_req_write;
      req_addr  <= i_DMEM_req_addr;
      req_wdata <= i_DMEM_req_wdata;
      req_wmask <= i_DMEM_req_wmask;
    end
  end

  always_ff @(posedge i_DMEM_clk) begin
    if (commit && in_range && acc_write) begin
      for (int i = 0; i < 8; i++) begin
        if (acc_wmask[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040386_dmem_resp.sv
// Bench for ysyx_22040386_dmem_resp: vector table on a LATENCY=2 instance plus
// stall, mid-transaction reset and back-to-back LATENCY=1 sequences.
module tb_ysyx_22040386_dmem_resp;

  typedef struct {
    logic        write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [63:0] req_addr, req_wdata, rsp_rdata;
  logic [7:0]  req_wmask;

  logic        req_valid1, req_ready1, req_write1, rsp_valid1, rsp_ready1, rsp_err1;
  logic [63:0] req_addr1, req_wdata1, rsp_rdata1;
  logic [7:0]  req_wmask1;

  int errors = 0;
  int checks = 0;
  vec_t vecs[16];

  always #5 clk = ~clk;

  ysyx_22040386_dmem_resp #(.LATENCY(2)) u_dut (
    .i_DMEM_clk(clk), .i_DMEM_rst(rst),
    .i_DMEM_req_valid(req_valid), .o_DMEM_req_ready(req_ready),
    .i_DMEM_req_write(req_write), .i_DMEM_req_addr(req_addr),
    .i_DMEM_req_wdata(req_wdata), .i_DMEM_req_wmask(req_wmask),
    .o_DMEM_rsp_valid(rsp_valid), .i_DMEM_rsp_ready(rsp_ready),
    .o_DMEM_rsp_rdata(rsp_rdata), .o_DMEM_rsp_err(rsp_err)
  );

  ysyx_22040386_dmem_resp #(.LATENCY(1)) u_dut1 (
    .i_DMEM_clk(clk), .i_DMEM_rst(rst),
    .i_DMEM_req_valid(req_valid1), .o_DMEM_req_ready(req_ready1),
    .i_DMEM_req_write(req_write1), .i_DMEM_req_addr(req_addr1),
    .i_DMEM_req_wdata(req_wdata1), .i_DMEM_req_wmask(req_wmask1),
    .o_DMEM_rsp_valid(rsp_valid1), .i_DMEM_rsp_ready(rsp_ready1),
    .o_DMEM_rsp_rdata(rsp_rdata1), .o_DMEM_rsp_err(rsp_err1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One full transaction on the LATENCY=2 instance with rsp_ready held high.
  task automatic txn(input vec_t v, input string name);
    int n;
    int lat;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_wmask = v.wmask;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_ready"}, 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_lat"}, 64'(lat), 64'd2);
    chk({name, "_rdata"}, rsp_rdata, v.exp_rdata);
    chk({name, "_err"}, 64'(rsp_err), 64'(v.exp_err));
    @(negedge clk);
    chk({name, "_done"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    vec_t v;
    int n;

    vecs[0]  = '{1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 1'b0};
    vecs[1]  = '{1'b0, 64'h8000_0008, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 1'b0};
    vecs[2]  = '{1'b1, 64'h8000_0008, 64'h0000_0000_AABB_0000, 8'h0C, 64'd0, 1'b0};
    vecs[3]  = '{1'b0, 64'h8000_000B, 64'd0, 8'h00, 64'h1122_3344_AABB_7788, 1'b0};
    vecs[4]  = '{1'b1, 64'h8000_0000, 64'hA0A1_A2A3_A4A5_A6A7, 8'hFF, 64'd0, 1'b0};
    vecs[5]  = '{1'b1, 64'h8000_1FF8, 64'hB0B1_B2B3_B4B5_B6B7, 8'hFF, 64'd0, 1'b0};
    vecs[6]  = '{1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, ONES, 1'b1};
    vecs[7]  = '{1'b0, 64'h8000_2000, 64'd0, 8'h00, ONES, 1'b1};
    vecs[8]  = '{1'b1, 64'h7FFF_FFF8, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, ONES, 1'b1};
    vecs[9]  = '{1'b1, 64'h8000_2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, ONES, 1'b1};
    vecs[10] = '{1'b0, 64'h0000_0000, 64'd0, 8'h00, ONES, 1'b1};
    vecs[11] = '{1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'hA0A1_A2A3_A4A5_A6A7, 1'b0};
    vecs[12] = '{1'b0, 64'h8000_1FF8, 64'd0, 8'h00, 64'hB0B1_B2B3_B4B5_B6B7, 1'b0};
    vecs[13] = '{1'b1, 64'h8000_0010, 64'h5555_6666_7777_8888, 8'hFF, 64'd0, 1'b0};
    vecs[14] = '{1'b1, 64'h8000_0010, ONES, 8'h00, 64'd0, 1'b0};
    vecs[15] = '{1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h5555_6666_7777_8888, 1'b0};

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    rsp_ready = 1'b1;
    req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_wmask1 = '0;
    rsp_ready1 = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_req_ready1", 64'(req_ready1), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < 16; i++) txn(vecs[i], $sformatf("vec%0d", i));

    // Response stall with rsp_ready low; a competing store must not be accepted
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h8000_0008;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_first_valid", 64'(rsp_valid), 64'd1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h8000_0008;
    req_wdata = 64'd0; req_wmask = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", i), 64'(rsp_valid), 64'd1);
      chk($sformatf("stall%0d_rdata", i), rsp_rdata, 64'h1122_3344_AABB_7788);
      chk($sformatf("stall%0d_req_ready", i), 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", 64'(rsp_valid), 64'd0);
    v = '{1'b0, 64'h8000_0008, 64'd0, 8'h00, 64'h1122_3344_AABB_7788, 1'b0};
    txn(v, "stall_after");

    // Reset while a store sits in WAIT: it must never commit
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h8000_0010;
    req_wdata = 64'h9999_9999_9999_9999; req_wmask = 8'hFF;
    chk("midrst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_req_ready_in_rst", 64'(req_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready_after", 64'(req_ready), 64'd1);
    chk("midrst_valid_after", 64'(rsp_valid), 64'd0);
    v = '{1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h5555_6666_7777_8888, 1'b0};
    txn(v, "midrst_old");

    // LATENCY=1 instance: req_valid held high, store then back-to-back loads
    @(negedge clk);
    req_valid1 = 1'b1; req_write1 = 1'b1; req_addr1 = 64'h8000_0020;
    req_wdata1 = 64'hC0FF_EE00_1234_5678; req_wmask1 = 8'hFF;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) req_write1 = 1'b0;
      if (k == 11) req_valid1 = 1'b0;
      if (k % 2 == 0) begin
        chk($sformatf("b2b%0d_valid", k), 64'(rsp_valid1), 64'd1);
        chk($sformatf("b2b%0d_req_ready", k), 64'(req_ready1), 64'd0);
        chk($sformatf("b2b%0d_rdata", k), rsp_rdata1,
            (k == 0) ? 64'd0 : 64'hC0FF_EE00_1234_5678);
        chk($sformatf("b2b%0d_err", k), 64'(rsp_err1), 64'd0);
      end else begin
        chk($sformatf("b2b%0d_valid", k), 64'(rsp_valid1), 64'd0);
        chk($sformatf("b2b%0d_req_ready", k), 64'(req_ready1), 64'd1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
